// File: rtl/byte_packer_if.sv
// byte_packer_if -- bundles the run/done configuration, the byte input lane
// and the packed-word output of byte_packer.
//   run, enabled, len   : start pulse and configuration (master -> slave)
//   in0, in0_valid      : input byte on in0[7:0] with its valid flag
//   out0, out0_valid    : packed word and its one-cycle valid pulse
//   out0_bytes          : number of populated lanes in out0
//   done                : high while the packer is idle
interface byte_packer_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(BYTES) + 1;

  logic              run;
  logic              enabled;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] in0;
  logic              in0_valid;
  logic [DATA_W-1:0] out0;
  logic              out0_valid;
  logic [CNT_W-1:0]  out0_bytes;
  logic              done;

  modport master (
    output run, enabled, len, in0, in0_valid,
    input  out0, out0_valid, out0_bytes, done
  );

  modport slave (
    input  run, enabled, len, in0, in0_valid,
    output out0, out0_valid, out0_bytes, done
  );
endinterface

// File: rtl/byte_packer.sv
// byte_packer -- packs a stream of bytes (one per cycle on in0[7:0]) into
// DATA_W-bit words, lane 0 holding the first byte of each group. A run pulse
// latches len; exactly len valid bytes are consumed, one registered word is
// emitted per DATA_W/8 bytes and a final partial word is zero-padded.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : byte_packer_if slave modport (run/enabled/len/in0/in0_valid in,
//         out0/out0_valid/out0_bytes/done out, all outputs registered)
module byte_packer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  byte_packer_if.slave  bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(BYTES);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE,
    PACK
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic [LEN_W-1:0]  remaining;

  logic [DATA_W-1:0] merged;
  logic              last_byte;
  logic              full_word;
  logic              unused_in0_hi;

  // Only the low lane of in0 carries data.
  assign unused_in0_hi = ^bus.in0[DATA_W-1:8];

  assign last_byte = (remaining == LEN_W'(1));
  assign full_word = (idx == IDX_W'(BYTES - 1));

  // Accumulator with the incoming byte dropped into lane idx; lanes above
  // idx are still zero because acc is cleared at the start of every group.
  always_comb begin
    merged = acc;
    for (int i = 0; i < BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        merged[8*i +: 8] = bus.in0[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      idx            <= '0;
      remaining      <= '0;
      bus.out0       <= '0;
      bus.out0_valid <= 1'b0;
      bus.out0_bytes <= '0;
      bus.done       <= 1'b1;
    end else begin
      bus.out0_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run && bus.enabled && (bus.len != '0)) begin
            state     <= PACK;
            remaining <= bus.len;
            idx       <= '0;
            acc       <= '0;
            bus.done  <= 1'b0;
          end
        end
        PACK: begin
          if (bus.in0_valid) begin
            remaining <= remaining - LEN_W'(1);
            if (full_word || last_byte) begin
              bus.out0       <= merged;
              bus.out0_bytes <= CNT_W'(idx) + CNT_W'(1);
              bus.out0_valid <= 1'b1;
              acc            <= '0;
              idx            <= '0;
            end else begin
              acc <= merged;
              idx <= idx + IDX_W'(1);
            end
            // remaining never drops below 1 in PACK, so it cannot underflow.
            if (last_byte) begin
              state    <= IDLE;
              bus.done <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          bus.done <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer -- scoreboard bench for byte_packer (DATA_W = 32).
// Stimulus builds each packet's bytes in a queue, computes the expected words
// arithmetically and pushes them to a scoreboard; a negedge monitor pops and
// compares whenever out0_valid is seen.
module tb_byte_packer;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int BYTES  = DATA_W / 8;

  typedef struct {
    logic [DATA_W-1:0] word;
    int                nbytes;
    bit                last;
  } exp_t;

  logic clk;
  logic rst;

  byte_packer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  byte_packer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t       exp_q[$];
  logic [7:0] pkt[$];
  int         total_checks = 0;
  int         passed_checks = 0;
  int         done_rises = 0;
  logic       prev_done = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word w holds bytes w*BYTES .. w*BYTES+BYTES-1, byte k in
  // bits 8k+7:8k, absent bytes are zero.
  task automatic push_expected(input int n);
    for (int w = 0; w * BYTES < n; w++) begin
      exp_t e;
      e.word   = '0;
      e.nbytes = (n - w * BYTES < BYTES) ? n - w * BYTES : BYTES;
      for (int k = 0; k < e.nbytes; k++) begin
        e.word = e.word | (DATA_W'(pkt[w * BYTES + k]) << (8 * k));
      end
      e.last = ((w + 1) * BYTES >= n);
      exp_q.push_back(e);
    end
  endtask

  // gap_mode: 0 contiguous, 1 one idle cycle between bytes, 2 random gaps.
  // busy_run raises a second run (len 2) alongside the second byte.
  task automatic applyStimulus(input int n, input int gap_mode, input bit busy_run);
    push_expected(n);
    bus.len     = LEN_W'(n);
    bus.enabled = 1'b1;
    bus.run     = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
    checkOutput("done_low_after_run", bus.done, 0);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (gap_mode == 1) ? ((i > 0) ? 1 : 0) :
            (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        bus.in0_valid = 1'b0;
        bus.in0       = $urandom;
        @(posedge clk); #1;
      end
      bus.in0       = $urandom;
      bus.in0[7:0]  = pkt[i];
      bus.in0_valid = 1'b1;
      if (busy_run && i == 1) begin
        bus.run = 1'b1;
        bus.len = LEN_W'(2);
      end
      @(posedge clk); #1;
      bus.run = 1'b0;
    end
    bus.in0_valid = 1'b0;
    checkOutput("done_high_after_last", bus.done, 1);
  endtask

  // Monitor: every out0_valid pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.done === 1'b1 && prev_done === 1'b0) done_rises++;
    prev_done = bus.done;
    if (bus.out0_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out0_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out0_word", bus.out0, e.word);
        checkOutput("out0_bytes", bus.out0_bytes, e.nbytes);
        checkOutput("done_with_word", bus.done, e.last);
      end
    end
  end

  initial begin
    int rises0;
    int waited;
    rst           = 1'b1;
    bus.run       = 1'b1;
    bus.enabled   = 1'b1;
    bus.len       = LEN_W'(4);
    bus.in0       = 32'h0000_00AB;
    bus.in0_valid = 1'b1;

    // Reset held for two cycles with run and in0_valid active.
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_out0", bus.out0, 0);
      checkOutput("reset_out0_valid", bus.out0_valid, 0);
      checkOutput("reset_done", bus.done, 1);
    end
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.run       = 1'b0;
    bus.in0_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_reset_done", bus.done, 1);
    checkOutput("idle_after_reset_valid", bus.out0_valid, 0);

    // Full words, contiguous stream.
    pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    applyStimulus(8, 0, 1'b0);

    // Partial tail with idle cycles between bytes.
    pkt = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    applyStimulus(6, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Zero length, then disabled, while bytes are supplied.
    for (int pass = 0; pass < 2; pass++) begin
      bus.enabled = (pass == 0);
      bus.len     = (pass == 0) ? LEN_W'(0) : LEN_W'(4);
      bus.run     = 1'b1;
      @(posedge clk); #1;
      bus.run = 1'b0;
      for (int i = 0; i < 4; i++) begin
        bus.in0       = $urandom;
        bus.in0_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput(pass == 0 ? "zero_len_done" : "disabled_done", bus.done, 1);
      end
      bus.in0_valid = 1'b0;
    end
    bus.enabled = 1'b1;

    // Second run while busy is ignored.
    rises0 = done_rises;
    pkt = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    applyStimulus(4, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_run_done_rises", done_rises - rises0, 1);

    // Reset after 3 of 4 bytes aborts the run without emitting a word.
    bus.len  = LEN_W'(4);
    bus.run  = 1'b1;
    @(posedge clk); #1;
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in0       = 32'h0000_00E0 + i;
      bus.in0_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_done", bus.done, 1);
    checkOutput("abort_out0_valid", bus.out0_valid, 0);
    @(posedge clk); #1;
    checkOutput("abort_no_pulse", bus.out0_valid, 0);
    pkt = {8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(4, 0, 1'b0);

    // Randomized packets.
    for (int p = 0; p < 20; p++) begin
      int n;
      n = int'($urandom_range(1, 12));
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      applyStimulus(n, 2, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end
endmodule

// File: doc/byte_packer.md
# byte_packer

Packs a stream of bytes, one per cycle on the low lane of `in0`, into `DATA_W`-bit words for the byte-swap stage directly downstream. Byte k of each group goes to lane k, so lane 0 holds the first byte. The packer is a run/done Versat unit. After each `run` pulse it consumes exactly `len` valid bytes, emits one registered word per `DATA_W/8` bytes, and zero-pads a final partial word.

## Interface
Parameters:
- `DATA_W`, 32: word width. Must be a multiple of 8 and at least 16. BYTES = DATA_W/8.
- `LEN_W`, 16: width of the byte-count configuration.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  start pulse; sampled only in IDLE.
- `enabled`  in  1  config; when 0, `run` is ignored.
- `len`  in  LEN_W  config; number of bytes to pack; latched on an accepted `run`.
- `in0`  in  DATA_W  input data; only `in0[7:0]` is used.
- `in0_valid`  in  1  the byte on `in0[7:0]` is present this cycle.
- `out0`  out  DATA_W  packed word; registered; holds its value between emissions.
- `out0_valid`  out  1  one-cycle pulse; `out0` is new this cycle.
- `out0_bytes`  out  clog2(BYTES)+1  number of populated lanes in `out0` (1..BYTES).
- `done`  out  1  level; 1 while IDLE, 0 while packing.

## Operation
- States: IDLE and PACK.
- IDLE -> PACK: on `run & enabled & (len != 0)`.
  - `remaining` is loaded with `len`.
  - `idx` is set to 0 and `acc` is cleared.
- IDLE stays IDLE on `run` with `len == 0` or `enabled == 0`. No word is emitted and `done` stays 1.
- `run` in PACK is ignored. `len` and `enabled` are not re-sampled in PACK.
- In PACK, with `in0_valid == 1`:
  - the byte is written to `acc[8*idx +: 8]`;
  - `remaining` is decremented;
  - `idx` is incremented.
- A cycle without `in0_valid` changes nothing. There is no backpressure and the upstream unit never stalls.
- Emit when `idx == BYTES-1` (full word) or `remaining == 1` (last byte):
  - `out0` gets `acc` merged with the current byte; unwritten lanes are 0;
  - `out0_bytes` gets `idx+1`;
  - `out0_valid` is 1 on the next cycle;
  - `acc` is cleared and `idx` wraps to 0.
- PACK -> IDLE on acceptance of the last byte (`remaining == 1`).
- Counters:
  - `remaining` is LEN_W bits and never underflows, because PACK exits at 1;
  - `idx` is clog2(BYTES) bits and wraps modulo BYTES.
- Reset values:
  - `out0` = 0, `out0_valid` = 0, `out0_bytes` = 0, `done` = 1;
  - internally, state = IDLE, `acc` = 0, `idx` = 0, `remaining` = 0.
- Reset mid-PACK aborts the run. Accumulated bytes are discarded and no word is emitted.

## Timing
- Latency from the last byte of a group (edge N) to `out0_valid` is 1 cycle: `out0_valid` is high in cycle N+1.
- `run` accepted at edge T:
  - `done` = 0 from cycle T+1;
  - the first byte can be accepted at edge T+1.
- Last byte accepted at edge L:
  - in cycle L+1, `done` = 1, `out0_valid` = 1 and `out0` holds the final word, all together;
  - a new `run` is accepted from edge L+1.
- With `in0_valid` held high and `len` = k·BYTES, `out0_valid` pulses once every BYTES cycles, k pulses in total.
- Outputs depend only on registers; there is no combinational path from `in0` to `out0`.

## Test plan
- **Reset and idle:**
  - Stimulus: assert `rst` for 2 cycles while `in0_valid = 1` and `run = 1`.
  - Response: `out0 = 0`, `out0_valid = 0` and `done = 1` throughout; in the cycle after release, with `run = 0`, still IDLE.
- **Full words, contiguous stream:**
  - Stimulus: DATA_W=32, `len = 8`, bytes 0x11..0x88 on 8 consecutive cycles.
  - Response:
    - `out0 = 0x44332211`, `out0_bytes = 4`, 1 cycle after byte 0x44;
    - `out0 = 0x88776655` in the same cycle that `done` rises.
- **Partial tail with gaps:**
  - Stimulus: `len = 6`, bytes 0xA1..0xA6 with `in0_valid` low on alternate cycles.
  - Response:
    - `out0 = 0xA4A3A2A1`, `out0_bytes = 4`;
    - then `out0 = 0x0000A6A5`, `out0_bytes = 2`;
    - idle cycles produce no extra pulses.
- **Zero length and disabled:**
  - Stimulus: `run` with `len = 0`; then `run` with `enabled = 0` and `len = 4`, while bytes are supplied.
  - Response: `done` stays 1 and `out0_valid` never pulses in either case.
- **`run` while busy:**
  - Stimulus: a second `run` with `len = 2` during a `len = 4` run.
  - Response: it is ignored; exactly one word, 4 bytes, is emitted and `done` rises once.
- **Reset mid-run:**
  - Stimulus: `rst` after 3 of 4 bytes; then a new `run` with `len = 4` and bytes 0x01..0x04.
  - Response: no emission at the abort; the next word is `out0 = 0x04030201` with no stale lanes.
